// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule and by the cipher datapath.
//   word_t      : one 32-bit key-schedule word
//   rkey_tbl_t  : 11 round keys of 4 words each, indexed [round][column]
//   rot_word()  : byte rotation used by the key schedule
//   xtime()     : multiply-by-x in GF(2^8), used to advance the round constant
package aes_pkg;

  localparam int NK = 4;
  localparam int NR = 10;
  localparam int NWORDS = NK * (NR + 1);
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [31:0] word_t;
  typedef word_t [0:10][0:3] rkey_tbl_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } ks_state_t;

  function automatic word_t rot_word(input word_t x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Shared by the key schedule (SubWord) and the SubBytes stage.
//   din  : input byte
//   dout : substituted byte
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128 key schedule: expands the cipher key into w[0..43],
// one word per clock, into a register file that feeds add_round_key.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : begin expansion (sampled in IDLE only)
//   key        : cipher key, w0 = key[127:96]; captured on the accepting edge
//   busy       : expansion in progress
//   done       : one-cycle pulse after w43 is written
//   key_valid  : round-key table complete and stable
//   round_key  : round_key[r][c] = w[4r+c], straight from registers
//
// state     | meaning
// ST_IDLE   | waiting for start; table holds last result (valid if key_valid)
// ST_EXPAND | writing w[idx], idx = 4..43, one word per clock
module aes_key_expand_iter
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output rkey_tbl_t    round_key
);

  generate
    if (NK != 4 || NR != 10) begin : g_bad_param
      $error("aes_key_expand_iter supports only NK=4, NR=10");
    end
  endgenerate

  localparam logic [5:0] FIRST_IDX = 6'd4;
  localparam logic [5:0] LAST_IDX  = 6'(NWORDS - 1);

  ks_state_t  state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       key_valid_q, key_valid_d;
  word_t      w_q [0:NWORDS-1];
  word_t      w_d [0:NWORDS-1];

  logic [5:0] rd_prev_idx;
  logic [5:0] rd_back4_idx;
  word_t      w_prev;
  word_t      w_back4;
  word_t      rot_prev;
  word_t      sub_word;
  word_t      temp;
  logic       grp_start;

  // Only meaningful in ST_EXPAND, where idx_q >= 4 so neither read underflows.
  assign rd_prev_idx  = idx_q - 6'd1;
  assign rd_back4_idx = idx_q - 6'd4;
  assign w_prev       = w_q[rd_prev_idx];
  assign w_back4      = w_q[rd_back4_idx];
  assign rot_prev     = rot_word(w_prev);
  assign grp_start    = (idx_q[1:0] == 2'd0);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_prev[8*b +: 8]),
      .dout (sub_word[8*b +: 8])
    );
  end

  assign temp = grp_start ? (sub_word ^ {rcon_q, 24'h0}) : w_prev;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rcon_d      = rcon_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    w_d         = w_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d[0]      = key[127:96];
          w_d[1]      = key[95:64];
          w_d[2]      = key[63:32];
          w_d[3]      = key[31:0];
          idx_d       = FIRST_IDX;
          rcon_d      = RCON_INIT;
          busy_d      = 1'b1;
          key_valid_d = 1'b0;
          state_d     = ST_EXPAND;
        end
      end

      ST_EXPAND: begin
        w_d[idx_q] = w_back4 ^ temp;
        if (grp_start) begin
          rcon_d = xtime(rcon_q);
        end
        if (idx_q == LAST_IDX) begin
          // idx parks at 43; the next start reloads it.
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 6'd0;
      rcon_q      <= RCON_INIT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      w_q         <= w_d;
    end
  end

  always_comb begin
    round_key = '0;
    for (int r = 0; r <= NR; r++) begin
      for (int c = 0; c < NK; c++) begin
        round_key[r][c] = w_q[4*r + c];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_aes_key_expand_iter.sv
module tb_aes_key_expand_iter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [127:0]       key;
  logic               busy;
  logic               done;
  logic               key_valid;
  aes_pkg::rkey_tbl_t round_key;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [7:0]  sb_m   [0:255];
  logic [31:0] exp_w  [0:43];
  logic [7:0]  rc_tab [0:9];

  aes_key_expand_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .round_key (round_key)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time expired, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sb_m[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword_m(input logic [31:0] x);
    return {sb_m[x[31:24]], sb_m[x[23:16]], sb_m[x[15:8]], sb_m[x[7:0]]};
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] t;
    int          rc = 1;
    for (int i = 0; i < 4; i++) exp_w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = exp_w[i-1];
      if (i % 4 == 0) begin
        t  = subword_m({t[23:0], t[31:24]}) ^ {8'(rc), 24'h0};
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      exp_w[i] = exp_w[i-4] ^ t;
    end
  endtask

  function automatic logic [127:0] row_model(input int r);
    return {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  // Starts at the next edge (E0); returns #1 after the edge that raised done,
  // or after the cycle budget runs out (lat then exceeds 41).
  task automatic do_expansion(input logic [127:0] k, input int inject_edge,
                              output int lat, output int busy_cyc,
                              output bit overlap, output bit busy_after_inject,
                              output bit busy0, output bit kv0);
    key   = k;
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    key     = rand_key();
    lat     = 1;
    busy0   = busy;
    kv0     = key_valid;
    busy_cyc = busy ? 1 : 0;
    overlap  = busy && key_valid;
    busy_after_inject = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (n == inject_edge) begin
        start = 1'b1;
        key   = '1;
      end
      @(posedge clk); #1;
      if (n == inject_edge) begin
        start = 1'b0;
        busy_after_inject = busy;
      end
      lat++;
      if (busy) busy_cyc++;
      if (busy && key_valid) overlap = 1'b1;
      if (done) break;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int nz = 0;
    rst_n = 1'b0;
    start = 1'b0;
    key   = rand_key();
    #2;
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        if (round_key[r][c] !== 32'h0) nz++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    checks++; if (nz !== 0) begin errors++; $display("FAIL reset_table: nonzero words %0d want 0", nz); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    int lat, bc;
    bit ov, bi, b0, k0;
    model_expand(FIPS_KEY);
    do_expansion(FIPS_KEY, 0, lat, bc, ov, bi, b0, k0);
    checks++; if (lat !== 41) begin errors++; $display("FAIL fips_latency: got %0d edges want 41", lat); end
    checks++; if (bc !== 40) begin errors++; $display("FAIL fips_busy_cycles: got %0d want 40", bc); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL fips_kv_while_busy: got %b want 0", ov); end
    checks++; if (b0 !== 1'b1 || k0 !== 1'b0) begin errors++; $display("FAIL fips_accept: busy=%b kv=%b want busy=1 kv=0", b0, k0); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL fips_key_valid: got %b want 1", key_valid); end
    checks++; if (round_key[1][0] !== 32'ha0fafe17) begin errors++; $display("FAIL fips_w4: got %h want a0fafe17", round_key[1][0]); end
    checks++;
    if (round_key[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", round_key[10]);
    end
    for (int r = 0; r < 11; r++) begin
      checks++;
      if (round_key[r] !== row_model(r)) begin
        errors++; $display("FAIL fips_row%0d: got %h want %h", r, round_key[r], row_model(r));
      end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fips_done_pulse: got %b want 0", done); end
    checks++; if (busy !== 1'b0 || key_valid !== 1'b1) begin errors++; $display("FAIL fips_idle: busy=%b kv=%b want busy=0 kv=1", busy, key_valid); end
  endtask

  task automatic test_rcon();
    logic [31:0] t;
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 1; i <= 10; i++) begin
      t = round_key[i][0] ^ round_key[i-1][0] ^
          subword_m({round_key[i-1][3][23:0], round_key[i-1][3][31:24]});
      checks++;
      if (t !== {rc_tab[i-1], 24'h0}) begin
        errors++; $display("FAIL rcon_group%0d: got %h want %h", i, t, {rc_tab[i-1], 24'h0});
      end
    end
  endtask

  task automatic test_zero_key();
    int lat, bc;
    bit ov, bi, b0, k0;
    do_expansion(128'h0, 0, lat, bc, ov, bi, b0, k0);
    checks++; if (lat !== 41) begin errors++; $display("FAIL zero_latency: got %0d want 41", lat); end
    checks++; if (k0 !== 1'b0) begin errors++; $display("FAIL zero_restart_kv: got %b want 0", k0); end
    checks++;
    if (round_key[1] !== 128'h62636363626363636263636362636363) begin
      errors++; $display("FAIL zero_rk1: got %h want 62636363626363636263636362636363", round_key[1]);
    end
    checks++;
    if (round_key[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      errors++; $display("FAIL zero_rk10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", round_key[10]);
    end
  endtask

  task automatic test_mid_start();
    int lat, bc;
    bit ov, bi, b0, k0;
    model_expand(FIPS_KEY);
    do_expansion(FIPS_KEY, 10, lat, bc, ov, bi, b0, k0);
    checks++; if (bi !== 1'b1) begin errors++; $display("FAIL mid_start_busy: got %b want 1", bi); end
    checks++; if (lat !== 41) begin errors++; $display("FAIL mid_start_latency: got %0d want 41", lat); end
    for (int r = 0; r < 11; r++) begin
      checks++;
      if (round_key[r] !== row_model(r)) begin
        errors++; $display("FAIL mid_start_row%0d: got %h want %h", r, round_key[r], row_model(r));
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, nz;
    bit ov, bi, b0, k0;
    key   = rand_key();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    nz = 0;
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        if (round_key[r][c] !== 32'h0) nz++;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags: busy=%b done=%b kv=%b want 0 0 0", busy, done, key_valid);
    end
    checks++; if (nz !== 0) begin errors++; $display("FAIL rst_mid_table: nonzero words %0d want 0", nz); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_expand(FIPS_KEY);
    do_expansion(FIPS_KEY, 0, lat, bc, ov, bi, b0, k0);
    checks++; if (lat !== 41) begin errors++; $display("FAIL rst_mid_latency: got %0d want 41", lat); end
    for (int r = 0; r < 11; r++) begin
      checks++;
      if (round_key[r] !== row_model(r)) begin
        errors++; $display("FAIL rst_mid_row%0d: got %h want %h", r, round_key[r], row_model(r));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit ov, bi, b0, k0;
    logic [127:0] k1;
    k1 = rand_key();
    do_expansion(k1, 0, lat, bc, ov, bi, b0, k0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
    model_expand(128'h0);
    do_expansion(128'h0, 0, lat, bc, ov, bi, b0, k0);
    checks++; if (b0 !== 1'b1 || k0 !== 1'b0) begin errors++; $display("FAIL b2b_accept: busy=%b kv=%b want busy=1 kv=0", b0, k0); end
    checks++; if (lat !== 41) begin errors++; $display("FAIL b2b_latency: got %0d want 41", lat); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL b2b_kv_while_busy: got %b want 0", ov); end
    for (int r = 0; r < 11; r++) begin
      checks++;
      if (round_key[r] !== row_model(r)) begin
        errors++; $display("FAIL b2b_row%0d: got %h want %h", r, round_key[r], row_model(r));
      end
    end
  endtask

  task automatic test_random();
    int lat, bc;
    bit ov, bi, b0, k0;
    logic [127:0] k;
    for (int t = 0; t < 4; t++) begin
      k = rand_key();
      model_expand(k);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      do_expansion(k, 0, lat, bc, ov, bi, b0, k0);
      checks++; if (lat !== 41 || bc !== 40) begin
        errors++; $display("FAIL rand%0d_timing: lat=%0d busy=%0d want 41 40", t, lat, bc);
      end
      checks++; if (ov !== 1'b0 || k0 !== 1'b0) begin
        errors++; $display("FAIL rand%0d_kv: overlap=%b kv_at_start=%b want 0 0", t, ov, k0);
      end
      for (int r = 0; r < 11; r++) begin
        checks++;
        if (round_key[r] !== row_model(r)) begin
          errors++; $display("FAIL rand%0d_row%0d: got %h want %h", t, r, round_key[r], row_model(r));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key   = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_rcon();
    test_zero_key();
    test_mid_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
